// File: rtl/cpu_step_clock.sv
// cpu_step_clock: clock-conditioning stage for the pipelined CPU.
// It turns a bouncing step key and two slide switches into a clean cpu_clk.
// There are two modes:
//    - single-step: one fixed-width pulse per key press
//    - free-run:    a square wave with a half-period of RUN_DIV cycles
// Optional feature macro: STEP_COUNT_EN. When it is defined, o_step_count counts
// cpu_clk rising edges. When it is undefined, no counter is built and
// o_step_count is tied to 0.

// Per-input conditioning lane: a 2-FF synchronizer followed by a
// consecutive-difference debouncer. RST_VAL is the input's idle level.
module cpu_step_clock_db #(
   parameter int unsigned CYCLES  = 500000,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_db
);
   // Count 0..CYCLES-1. Keep at least one bit when CYCLES is 1.
   localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic          r_s1;
   logic          r_s2;
   logic          r_db;
   logic [CW-1:0] r_cnt;

   // Two-stage synchronizer. It resets to the idle level so that reset
   // release cannot look like an input change.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= RST_VAL;
         r_s2 <= RST_VAL;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
      end
   end

   // Accept a new level only after it has differed from the accepted one
   // for CYCLES consecutive cycles. Any agreement restarts the count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_db  <= RST_VAL;
         r_cnt <= '0;
      end else if (r_s2 == r_db) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
         r_db  <= r_s2;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_db = r_db;
endmodule

module cpu_step_clock #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned PULSE_CYCLES    = 4,
   parameter int unsigned RUN_DIV         = 2500000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_step_btn_n,
   input  logic             i_run_sw,
   input  logic             i_hlt_sw,
   output logic             o_cpu_clk,
   output logic             o_running,
   output logic [CNT_W-1:0] o_step_count
);
   // One shared timer serves both the step pulse width and the run half-period.
   localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam int unsigned DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam int unsigned TW = (PW > DW) ? PW : DW;

   localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] RUN_LOAD   = TW'(RUN_DIV - 1);

   // Lane order is {hlt, run, btn_n}. Idle levels: key released, both switches off.
   localparam logic [2:0] DB_RST = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STEP_HI,
      S_STEP_WAIT,
      S_RUN_HI,
      S_RUN_LO
   } state_t;

   logic [2:0]    w_raw;
   logic [2:0]    w_db;
   logic          w_btn_db;
   logic          w_run;
   logic          w_hlt;
   logic          w_press;
   logic          w_go_run_idle;
   logic          w_go_step;
   logic          w_lo_done;
   logic          w_go_run_lo;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_cpu_clk;
   logic          r_running;
   logic          r_btn_prev;

   assign w_raw = {i_hlt_sw, i_run_sw, i_step_btn_n};

   for (genvar g = 0; g < 3; g++) begin : g_db
      cpu_step_clock_db #(
         .CYCLES  (DEBOUNCE_CYCLES),
         .RST_VAL (DB_RST[g])
      ) u_db (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_raw (w_raw[g]),
         .o_db  (w_db[g])
      );
   end

   assign w_btn_db = w_db[0];
   assign w_run    = w_db[1];
   assign w_hlt    = w_db[2];

   // Remember the previous debounced key level so that a press shows up as
   // a single-cycle strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_btn_prev <= 1'b1;
      else       r_btn_prev <= w_btn_db;
   end

   assign w_press = r_btn_prev & ~w_btn_db;

   // Transitions that raise cpu_clk. Run has priority over a press that
   // arrives in the same cycle, and halt overrides both.
   assign w_go_run_idle = (r_state == S_IDLE) && !w_hlt && w_run;
   assign w_go_step     = (r_state == S_IDLE) && !w_hlt && !w_run && w_press;
   assign w_lo_done     = (r_state == S_RUN_LO) && (r_timer == '0);
   assign w_go_run_lo   = w_lo_done && !w_hlt && w_run;

   // Main sequencer. A started pulse or run period always completes, so
   // cpu_clk never produces a runt pulse outside of reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_cpu_clk <= 1'b0;
         r_running <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_go_run_idle) begin
                  r_state   <= S_RUN_HI;
                  r_timer   <= RUN_LOAD;
                  r_cpu_clk <= 1'b1;
                  r_running <= 1'b1;
               end else if (w_go_step) begin
                  r_state   <= S_STEP_HI;
                  r_timer   <= PULSE_LOAD;
                  r_cpu_clk <= 1'b1;
               end
            end
            S_STEP_HI: begin
               if (r_timer == '0) begin
                  r_state   <= S_STEP_WAIT;
                  r_cpu_clk <= 1'b0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_STEP_WAIT: begin
               // Holding the key down produces no further pulses.
               if (w_btn_db) r_state <= S_IDLE;
            end
            S_RUN_HI: begin
               if (r_timer == '0) begin
                  r_state   <= S_RUN_LO;
                  r_timer   <= RUN_LOAD;
                  r_cpu_clk <= 1'b0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_RUN_LO: begin
               if (w_go_run_lo) begin
                  r_state   <= S_RUN_HI;
                  r_timer   <= RUN_LOAD;
                  r_cpu_clk <= 1'b1;
               end else if (w_lo_done) begin
                  r_state   <= S_IDLE;
                  r_running <= 1'b0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_timer   <= '0;
               r_cpu_clk <= 1'b0;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign o_cpu_clk = r_cpu_clk;
   assign o_running = r_running;

`ifdef STEP_COUNT_EN
   logic             w_rise;
   logic [CNT_W-1:0] r_step_count;

   assign w_rise = w_go_run_idle | w_go_step | w_go_run_lo;

   // Count cpu_clk rising edges on the same clock edge that raises cpu_clk.
   // The counter wraps naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_step_count <= '0;
      else if (w_rise) r_step_count <= r_step_count + CNT_W'(1);
   end

   assign o_step_count = r_step_count;
`else
   assign o_step_count = '0;
`endif
endmodule

// File: tb/tb_cpu_step_clock.sv
// Bench for cpu_step_clock. It runs with short parameters
// (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, RUN_DIV=5). A second instance with a
// 2-bit counter shares the same inputs so that counter wrap is exercised.
module tb_cpu_step_clock;
   localparam int DEB  = 4;
   localparam int PC   = 3;
   localparam int RD   = 5;
   localparam int MAXN = 1200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_n = 1'b1;
   logic        run_sw = 1'b0;
   logic        hlt_sw = 1'b0;
   logic        cpu_clk, running, cpu_clk2, running2;
   logic [15:0] step_count;
   logic [1:0]  step_count2;

   always #5 clk = ~clk;

   cpu_step_clock #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PC), .RUN_DIV(RD), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_step_btn_n(btn_n), .i_run_sw(run_sw), .i_hlt_sw(hlt_sw),
      .o_cpu_clk(cpu_clk), .o_running(running), .o_step_count(step_count));

   cpu_step_clock #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PC), .RUN_DIV(RD), .CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_step_btn_n(btn_n), .i_run_sw(run_sw), .i_hlt_sw(hlt_sw),
      .o_cpu_clk(cpu_clk2), .o_running(running2), .o_step_count(step_count2));

   int n_chk = 0;
   int n_fail = 0;
   int n;                                   // number of stimulus cycles
   logic [2:0] in_v [0:MAXN];               // raw {hlt, run, btn_n} before edge e
   logic [2:0] db_v [0:MAXN];               // model debounced values after edge e
   logic       ex_clk [0:MAXN];
   logic       ex_run [0:MAXN];
   int         ex_cnt [0:MAXN];
   logic       ac_clk [0:MAXN];

   typedef struct {
      logic b, r, h;
      int   cyc;
      bit   bounce;
      int   exp_rises;   // cumulative cpu_clk rising edges at segment end
   } vec_t;
   vec_t tbl [13];
   int   seg_start [13];
   int   seg_end [13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic void clear_stim();
      n = 0;
      in_v[0] = 3'b001;
   endfunction

   function automatic void add(input logic b, input logic r, input logic h);
      n++;
      in_v[n] = {h, r, b};
   endfunction

   function automatic void put(input int e, input logic c, input logic r, input int cnt);
      if (e <= n) begin
         ex_clk[e] = c;
         ex_run[e] = r;
         ex_cnt[e] = cnt;
      end
   endfunction

   // Reference model, derived from the stated rules.
   // Debounce: a level is accepted once the synchronized input (the raw
   // input delayed by two cycles) has disagreed with the accepted level
   // over the last DEB samples.
   // Sequencer: a sequence of whole bursts. A run period is 2*RD cycles
   // (the first half high). A step is PC cycles high, followed by waiting
   // for the key to be released.
   task automatic model();
      logic [2:0] rv;
      logic       s, flip, press, go_run;
      int         k, e, cnt;
      rv = 3'b001;
      db_v[0] = rv;
      for (int t = 1; t <= n; t++) begin
         db_v[t] = db_v[t-1];
         for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
               k = t - j;
               s = (k >= 1) ? in_v[k-1][b] : rv[b];
               if (s == db_v[t-1][b]) flip = 1'b0;
            end
            if (flip) db_v[t][b] = ~db_v[t-1][b];
         end
      end
      e = 1;
      cnt = 0;
      while (e <= n) begin
         go_run = !db_v[e-1][2] && db_v[e-1][1];
         press  = ((e >= 2) ? db_v[e-2][0] : 1'b1) && !db_v[e-1][0];
         if (go_run) begin
            cnt++;
            for (int i = 0; i < 2*RD; i++) put(e + i, (i < RD), 1'b1, cnt);
            e += 2*RD;
            if (e <= n && !(!db_v[e-1][2] && db_v[e-1][1])) begin
               put(e, 1'b0, 1'b0, cnt);
               e++;
            end
         end else if (!db_v[e-1][2] && press) begin
            cnt++;
            for (int i = 0; i < PC; i++) put(e + i, 1'b1, 1'b0, cnt);
            e += PC;
            put(e, 1'b0, 1'b0, cnt);
            e++;
            while (e <= n && !db_v[e-1][0]) begin
               put(e, 1'b0, 1'b0, cnt);
               e++;
            end
            put(e, 1'b0, 1'b0, cnt);
            e++;
         end else begin
            put(e, 1'b0, 1'b0, cnt);
            e++;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      {hlt_sw, run_sw, btn_n} = 3'b001;
      repeat (2) @(negedge clk);
      check("reset_cpu_clk", cpu_clk, 0);
      check("reset_running", running, 0);
      check("reset_step_count", step_count, 0);
      rst = 1'b0;
   endtask

   task automatic run_trace(input string tag);
      logic [31:0] want_cnt, want_cnt2;
      model();
      do_reset();
      ac_clk[0] = 1'b0;
      for (int e = 1; e <= n; e++) begin
         {hlt_sw, run_sw, btn_n} = in_v[e];
         @(posedge clk);
         @(negedge clk);
         ac_clk[e] = cpu_clk;
`ifdef STEP_COUNT_EN
         want_cnt  = ex_cnt[e] % 65536;
         want_cnt2 = ex_cnt[e] % 4;
`else
         want_cnt  = 0;
         want_cnt2 = 0;
`endif
         check({tag, "_cpu_clk"}, cpu_clk, ex_clk[e]);
         check({tag, "_running"}, running, ex_run[e]);
         check({tag, "_step_count"}, step_count, want_cnt);
         check({tag, "_step_count_w2"}, step_count2, want_cnt2);
      end
   endtask

   function automatic int rises_upto(input int last);
      int c = 0;
      for (int e = 1; e <= last; e++) if (ac_clk[e] && !ac_clk[e-1]) c++;
      return c;
   endfunction

   function automatic int first_rise(input int from);
      for (int e = from; e <= n; e++) if (ac_clk[e] && !ac_clk[e-1]) return e;
      return -1000;
   endfunction

   function automatic int hi_width(input int from);
      int w = 0;
      for (int e = from; e <= n && ac_clk[e]; e++) w++;
      return w;
   endfunction

   initial begin
      int r, hi_cnt, len;
      logic rb, rr, rh;
      bit found;
      // Directed segments:
      //   bounce, long hold, second press, run, halt during RUN_HI,
      //   presses while halted
      tbl[0]  = '{1'b1, 1'b0, 1'b0,  10, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0,  20, 1'b1, 0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 100, 1'b0, 1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0,  20, 1'b0, 1};
      tbl[4]  = '{1'b0, 1'b0, 1'b0,  20, 1'b0, 2};
      tbl[5]  = '{1'b1, 1'b0, 1'b0,  20, 1'b0, 2};
      tbl[6]  = '{1'b1, 1'b1, 1'b0,  60, 1'b0, 8};
      tbl[7]  = '{1'b1, 1'b0, 1'b0,  20, 1'b0, 8};
      tbl[8]  = '{1'b1, 1'b1, 1'b0,   1, 1'b0, 8};
      tbl[9]  = '{1'b1, 1'b1, 1'b1,  30, 1'b0, 9};
      tbl[10] = '{1'b0, 1'b1, 1'b1,  20, 1'b0, 9};
      tbl[11] = '{1'b1, 1'b0, 1'b1,  20, 1'b0, 9};
      tbl[12] = '{1'b1, 1'b0, 1'b0,  20, 1'b0, 9};

      clear_stim();
      for (int i = 0; i < 13; i++) begin
         seg_start[i] = n + 1;
         for (int k = 0; k < tbl[i].cyc; k++)
            add(tbl[i].bounce ? (tbl[i].b ^ ((k / 2) % 2 != 0)) : tbl[i].b, tbl[i].r, tbl[i].h);
         seg_end[i] = n;
      end
      run_trace("dir");

      for (int i = 0; i < 13; i++) check($sformatf("rises_seg%0d", i), rises_upto(seg_end[i]), tbl[i].exp_rises);

      // Bounced press: a single 3-cycle pulse 2+4+1 cycles after the key settles.
      r = first_rise(seg_start[2]);
      check("bounce_pulse_offset", r - (seg_start[2] - 1), 7);
      check("bounce_pulse_width", hi_width(r), PC);

      // Free-run: 10-cycle period, 5 cycles high.
      r = first_rise(seg_start[6]);
      check("run_first_offset", r - (seg_start[6] - 1), 7);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("run_rise%0d", k), ac_clk[r + 10*k] && !ac_clk[r + 10*k - 1], 1);
         check($sformatf("run_width%0d", k), hi_width(r + 10*k), RD);
      end

      // Halt during RUN_HI: one full high and one full low, then held low.
      r = first_rise(seg_start[8]);
      check("halt_rise_offset", r - (seg_start[8] - 1), 7);
      check("halt_hi_width", hi_width(r), RD);
      hi_cnt = 0;
      for (int e = r + RD; e <= seg_end[12]; e++) if (ac_clk[e]) hi_cnt++;
      check("halt_stays_low", hi_cnt, 0);

      // Reset while cpu_clk is high: the outputs clear in the same cycle.
      do_reset();
      run_sw = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (cpu_clk) found = 1'b1;
      end
      check("rst_mid_reached_hi", found, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_cpu_clk", cpu_clk, 0);
      check("rst_mid_running", running, 0);
      check("rst_mid_step_count", step_count, 0);
      check("rst_mid_step_count_w2", step_count2, 0);
      run_sw = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Randomized input histories checked cycle by cycle against the model.
      for (int t = 0; t < 3; t++) begin
         clear_stim();
         while (n < 400) begin
            rb = ($urandom_range(0, 1) != 0);
            rr = ($urandom_range(0, 3) == 0);
            rh = ($urandom_range(0, 5) == 0);
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) add(rb, rr, rh);
         end
         run_trace($sformatf("rnd%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule
